seq_multiplier: RTL

Parametrised, iterative shift-add multiplier. It is the sequential successor to the combinational 16x16 multiplier: A*B is computed over WIDTH clock cycles instead of with a full array. The block adds a start/busy/done handshake, selectable signed (two's complement) or unsigned mode, and a held result register. It is used where area matters more than latency; it is driven by a controller or testbench that issues one multiply at a time.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mag_abs.sv | 16 +
 rtl/seq_multiplier.sv | 118 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encodings and the default operand width.
package mul_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/mag_abs.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and the final product sign fix.
module mag_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negate when requested, pass through otherwise
  always_comb begin
    o_val = i_neg ? (~i_val + W'(1)) : i_val;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Signed operands are handled as magnitudes plus a result sign.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH:0]     r_acc;
  logic [2*WIDTH:0]     w_acc_step;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_accept;
  logic                 w_last;

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;

  assign w_accept = start & (r_state != S_CALC);
  assign w_last   = (r_state == S_CALC) &&
                    (r_cnt == CNT_W'(WIDTH - 1));

  mag_abs #(.W(WIDTH)) u_abs_a (
    .i_val (A),
    .i_neg (signed_mode & A[WIDTH-1]),
    .o_val (w_mag_a)
  );

  mag_abs #(.W(WIDTH)) u_abs_b (
    .i_val (B),
    .i_neg (signed_mode & B[WIDTH-1]),
    .o_val (w_mag_b)
  );

  // Add multiplicand into the upper half when multiplier LSB is set, then shift
  always_comb begin
    w_sum = r_acc[2*WIDTH:WIDTH];
    if (r_acc[0]) begin
      w_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
    end
    w_acc_step = {1'b0, w_sum, r_acc[WIDTH-1:1]};
  end

  mag_abs #(.W(2*WIDTH)) u_abs_p (
    .i_val (w_acc_step[2*WIDTH-1:0]),
    .i_neg (r_neg),
    .o_val (w_res)
  );

  // Next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register with registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_CALC);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Operand latch, accumulator, step counter and held product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_b};
      r_mcand <= w_mag_a;
      r_neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_p <= w_res;
      end
    end
  end

endmodule
